// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with per-frame divisor, parity mode and stop-bit count.
// All frame settings are latched on accept, so input changes mid-frame have no effect.
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              TX,
    output logic              busy,
    output logic              tx_done
);
    localparam int BW = $clog2(DATA_W + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              par_en;
    logic              par_bit;
    logic              two_stop;
    logic              stop_cnt;
    logic              bit_end;
    assign tx_ready = state == IDLE;
    assign bit_end  = div_cnt == div - DIV_W'(1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            div      <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            two_stop <= 1'b0;
            stop_cnt <= 1'b0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                if (tx_valid) begin
                    state    <= START;
                    shift    <= tx_data;
                    div      <= (baud_div == '0) ? DIV_W'(1) : baud_div;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    par_en   <= parity_mode == 2'b01 || parity_mode == 2'b10;
                    par_bit  <= ^tx_data ^ (parity_mode == 2'b10);
                    two_stop <= stop2;
                    stop_cnt <= 1'b0;
                    TX       <= 1'b0;
                    busy     <= 1'b1;
                end
            end else if (!bit_end) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                // bit boundary: TX is loaded with the next bit so it stays registered
                div_cnt <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        TX    <= shift[0];
                    end
                    DATA: begin
                        shift <= shift >> 1;
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en ? PARITY : STOP;
                            TX      <= par_en ? par_bit : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            TX      <= shift[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        TX    <= 1'b1;
                    end
                    default: begin
                        if (two_stop && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            stop_cnt <= 1'b0;
                            busy     <= 1'b0;
                            tx_done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed and random frames checked against a bit-list model of the serial line.
module tb_uart_tx_cfg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] baud_div = '0;
    logic [1:0]  parity_mode = '0;
    logic        stop2 = 1'b0;
    logic        TX;
    logic        busy;
    logic        tx_done;
    int          checks = 0;
    int          passes = 0;
    int          frame = 0;

    uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
        .TX(TX), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s (frame %0d): got %0h expected %0h", tag, frame, obs, exp);
    endtask

    // Called at a negedge with tx_ready expected high; accept happens on the next posedge.
    task automatic run_frame(input logic [7:0] d, input int div, input logic [1:0] pm,
                             input logic s2, input bit hold);
        int n;
        bit bits[$];
        frame++;
        n = (div == 0) ? 1 : div;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pm == 2'b01) bits.push_back(^d);
        if (pm == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        chk("ready_before_accept", tx_ready, 1);
        tx_data = d;
        baud_div = 16'(div);
        parity_mode = pm;
        stop2 = s2;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = hold;
        tx_data = 8'($urandom);
        baud_div = 16'($urandom_range(0, 7));
        parity_mode = 2'($urandom);
        stop2 = 1'($urandom);
        foreach (bits[i]) begin
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                chk($sformatf("tx_bit%0d_cyc%0d", i, c), TX, bits[i]);
                chk("busy_in_frame", busy, 1);
                chk("ready_in_frame", tx_ready, 0);
                chk("done_in_frame", tx_done, 0);
            end
        end
        @(negedge clk);
        chk("done_pulse", tx_done, 1);
        chk("busy_after", busy, 0);
        chk("ready_after", tx_ready, 1);
        chk("tx_idle_after", TX, 1);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_tx", TX, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(8'h05, 4, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", tx_done, 0);
        run_frame(8'h07, 2, 2'b01, 1'b0, 1'b0);
        run_frame(8'h07, 2, 2'b10, 1'b0, 1'b0);
        run_frame(8'hFF, 3, 2'b00, 1'b1, 1'b0);
        run_frame(8'h5C, 2, 2'b11, 1'b1, 1'b0);
        run_frame(8'hA5, 2, 2'b01, 1'b0, 1'b1);
        run_frame(8'h3C, 2, 2'b01, 1'b0, 1'b1);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("no_third_accept", busy, 0);
        chk("tx_idle_gap", TX, 1);
        for (int k = 0; k < 10; k++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 5)), 2'($urandom), 1'($urandom), 1'b0);
        end
        frame++;
        tx_data = 8'h52;
        baud_div = 16'd4;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_data_bit3", TX, 0);
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx", TX, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", tx_ready, 1);
        chk("async_rst_done", tx_done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold_done", tx_done, 0);
            chk("rst_hold_tx", TX, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_done", tx_done, 0);
        run_frame(8'h96, 0, 2'b01, 1'b1, 1'b0);
        run_frame(8'($urandom), 1, 2'b10, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
